// File: rtl/cosim_commit_queue.sv
// Ordering queue between the core's commit/trap taps and the cosim checker:
// compacts sparse lane valids, buffers bursts, and keeps traps behind their commits.
module cosim_commit_queue #(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 64,
    parameter int INST_BITS    = 32,
    parameter int RD           = 5,
    parameter int DEPTH        = 16,
    localparam int REC_W       = 3*XLEN+INST_BITS+2*RD+4,
    localparam int CNT_W       = $clog2(DEPTH)+1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [COMMIT_WIDTH-1:0]       in_valid,
    input  logic [REC_W*COMMIT_WIDTH-1:0] in_rec,
    input  logic                          in_int_xcpt,
    input  logic [XLEN-1:0]               in_cause,
    input  logic                          drain_en,
    output logic [COMMIT_WIDTH-1:0]       out_valid,
    output logic [REC_W*COMMIT_WIDTH-1:0] out_rec,
    output logic                          out_int_xcpt,
    output logic [XLEN-1:0]               out_cause,
    output logic [CNT_W-1:0]              count,
    output logic                          overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = REC_W + 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [AW-1:0]    ptr_t;

    // Entry MSB flags a trap; a trap entry carries only its cause in the low XLEN bits.
    logic [ENT_W-1:0] mem [DEPTH];
    ptr_t wr_ptr;
    ptr_t rd_ptr;

    // Stage p0: enqueue compaction and dequeue scan, both from pre-edge state
    cnt_t n_lanes_p0;
    cnt_t n_push_p0;
    cnt_t free_p0;
    logic accept_p0;
    ptr_t lane_addr_p0 [COMMIT_WIDTH];
    ptr_t trap_addr_p0;

    always_comb begin
        n_lanes_p0 = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_addr_p0[i] = wr_ptr + ptr_t'(n_lanes_p0);
            if (in_valid[i]) n_lanes_p0 = n_lanes_p0 + cnt_t'(1);
        end
        trap_addr_p0 = wr_ptr + ptr_t'(n_lanes_p0);
        n_push_p0    = n_lanes_p0 + cnt_t'(in_int_xcpt);
        free_p0      = cnt_t'(DEPTH) - count;
        accept_p0    = (n_push_p0 <= free_p0);
    end

    cnt_t                          n_cmt_p0;
    cnt_t                          n_pop_p0;
    logic                          stop_p0;
    logic                          trap_pop_p0;
    ptr_t                          rd_idx_p0;
    ptr_t                          trap_rd_p0;
    logic [COMMIT_WIDTH-1:0]       vld_p0;
    logic [REC_W*COMMIT_WIDTH-1:0] rec_p0;
    logic [XLEN-1:0]               cause_p0;

    always_comb begin
        n_cmt_p0  = '0;
        stop_p0   = 1'b0;
        vld_p0    = '0;
        rec_p0    = '0;
        rd_idx_p0 = rd_ptr;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            rd_idx_p0 = rd_ptr + ptr_t'(i);
            if (!stop_p0 && drain_en && (cnt_t'(i) < count) && !mem[rd_idx_p0][REC_W]) begin
                vld_p0[i]                = 1'b1;
                rec_p0[i*REC_W +: REC_W] = mem[rd_idx_p0][REC_W-1:0];
                n_cmt_p0                 = n_cmt_p0 + cnt_t'(1);
            end else begin
                stop_p0 = 1'b1;
            end
        end
        // The scan stops at a trap, so the entry right after the popped commits is the only trap candidate.
        trap_rd_p0  = rd_ptr + ptr_t'(n_cmt_p0);
        trap_pop_p0 = drain_en && (n_cmt_p0 < count) && mem[trap_rd_p0][REC_W];
        cause_p0    = trap_pop_p0 ? mem[trap_rd_p0][XLEN-1:0] : '0;
        n_pop_p0    = n_cmt_p0 + cnt_t'(trap_pop_p0);
    end

    // Stage p1: storage write and registered outputs
    always_ff @(posedge clock) begin
        if (accept_p0) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (in_valid[i]) mem[lane_addr_p0[i]] <= {1'b0, in_rec[i*REC_W +: REC_W]};
            end
            if (in_int_xcpt) mem[trap_addr_p0] <= {1'b1, {(REC_W-XLEN){1'b0}}, in_cause};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            out_valid    <= '0;
            out_rec      <= '0;
            out_int_xcpt <= 1'b0;
            out_cause    <= '0;
        end else begin
            wr_ptr       <= accept_p0 ? wr_ptr + ptr_t'(n_push_p0) : wr_ptr;
            rd_ptr       <= rd_ptr + ptr_t'(n_pop_p0);
            count        <= count + (accept_p0 ? n_push_p0 : cnt_t'(0)) - n_pop_p0;
            overflow     <= overflow | ~accept_p0;
            out_valid    <= vld_p0;
            out_rec      <= rec_p0;
            out_int_xcpt <= trap_pop_p0;
            out_cause    <= cause_p0;
        end
    end

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Directed bench for cosim_commit_queue: compaction, trap ordering, throttle/overflow,
// pointer wrap against a pc scoreboard, and async reset.
module tb_cosim_commit_queue;

    localparam int W     = 2;
    localparam int XLEN  = 64;
    localparam int REC_W = 3*64+32+2*5+4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [W-1:0]         in_valid;
    logic [REC_W*W-1:0]   in_rec;
    logic                 in_int_xcpt;
    logic [XLEN-1:0]      in_cause;
    logic                 drain_en;
    logic [W-1:0]         out_valid;
    logic [REC_W*W-1:0]   out_rec;
    logic                 out_int_xcpt;
    logic [XLEN-1:0]      out_cause;
    logic [4:0]           count;
    logic                 overflow;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] pc_n;
    logic [1:0]  v;

    cosim_commit_queue dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_rec(in_rec),
        .in_int_xcpt(in_int_xcpt), .in_cause(in_cause), .drain_en(drain_en),
        .out_valid(out_valid), .out_rec(out_rec), .out_int_xcpt(out_int_xcpt),
        .out_cause(out_cause), .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input logic [63:0] pc);
        return {pc, pc[31:0] ^ 32'hA5A5_A5A5, ~pc, pc + 64'd1, pc[13:0]};
    endfunction

    function automatic logic [63:0] out_pc(input int l);
        return out_rec[(l+1)*REC_W-1 -: XLEN];
    endfunction

    task automatic clear_in();
        in_valid    = '0;
        in_rec      = '0;
        in_int_xcpt = 1'b0;
        in_cause    = '0;
    endtask

    task automatic set_lane(input int l, input logic [63:0] pc);
        in_valid[l]              = 1'b1;
        in_rec[l*REC_W +: REC_W] = mk_rec(pc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        drain_en = 1'b1;
        clear_in();
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_xcpt", out_int_xcpt, 0);
        tick();
        reset = 1'b0;

        // sparse lane 1 lands on output lane 0
        set_lane(1, 64'h8000_0004);
        tick();
        clear_in();
        check("sparse_early", out_valid, 0);
        tick();
        check("sparse_valid", out_valid, 2'b01);
        check("sparse_pc", out_pc(0), 64'h8000_0004);
        check("sparse_rec", out_rec[0 +: REC_W], mk_rec(64'h8000_0004));
        check("sparse_lane1", out_rec[REC_W +: REC_W], 0);

        // two commits plus trap in one cycle come out together
        set_lane(0, 64'h100);
        set_lane(1, 64'h104);
        in_int_xcpt = 1'b1;
        in_cause    = 64'h8000_0000_0000_0007;
        tick();
        clear_in();
        tick();
        check("ord_valid", out_valid, 2'b11);
        check("ord_pc0", out_pc(0), 64'h100);
        check("ord_pc1", out_pc(1), 64'h104);
        check("ord_xcpt", out_int_xcpt, 1);
        check("ord_cause", out_cause, 64'h8000_0000_0000_0007);
        check("ord_count", count, 0);

        // three commits then a trap: trap waits for the third commit
        drain_en = 1'b0;
        set_lane(0, 64'h200);
        set_lane(1, 64'h204);
        tick();
        clear_in();
        set_lane(0, 64'h208);
        in_int_xcpt = 1'b1;
        in_cause    = 64'h5;
        tick();
        clear_in();
        check("blk_count", count, 4);
        drain_en = 1'b1;
        tick();
        check("blk1_valid", out_valid, 2'b11);
        check("blk1_xcpt", out_int_xcpt, 0);
        check("blk1_cause", out_cause, 0);
        check("blk1_pc1", out_pc(1), 64'h204);
        tick();
        check("blk2_valid", out_valid, 2'b01);
        check("blk2_pc0", out_pc(0), 64'h208);
        check("blk2_xcpt", out_int_xcpt, 1);
        check("blk2_cause", out_cause, 64'h5);
        tick();
        check("blk3_valid", out_valid, 0);
        check("blk3_xcpt", out_int_xcpt, 0);

        // lone trap at head
        in_int_xcpt = 1'b1;
        in_cause    = 64'h3;
        tick();
        clear_in();
        tick();
        check("solo_valid", out_valid, 0);
        check("solo_xcpt", out_int_xcpt, 1);
        check("solo_cause", out_cause, 64'h3);

        // throttle: fill to DEPTH, then push while full and popping
        drain_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            clear_in();
            set_lane(0, 64'h1000 + 64'(8*c));
            set_lane(1, 64'h1004 + 64'(8*c));
            tick();
        end
        clear_in();
        check("full_count", count, 16);
        check("full_ovf0", overflow, 0);
        check("full_out", out_valid, 0);
        drain_en = 1'b1;
        set_lane(0, 64'h2000);
        set_lane(1, 64'h2004);
        tick();
        clear_in();
        check("drop_ovf", overflow, 1);
        check("drop_count", count, 14);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            check("thr_valid", out_valid, 2'b11);
            check("thr_pc0", out_pc(0), 64'h1000 + 64'(8*c));
            check("thr_pc1", out_pc(1), 64'h1004 + 64'(8*c));
        end
        tick();
        check("thr_empty", out_valid, 0);
        check("thr_count", count, 0);
        check("thr_ovf_sticky", overflow, 1);

        // wrap: random sparse pushes with continuous drain
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrap_ovf_clr", overflow, 0);
        pc_n = 64'h4000;
        for (int c = 0; c < 46; c++) begin
            clear_in();
            if (c < 40) begin
                v = 2'($urandom_range(0, 3));
                for (int l = 0; l < W; l++) begin
                    if (v[l]) begin
                        set_lane(l, pc_n);
                        exp_q.push_back(pc_n);
                        pc_n = pc_n + 64'd4;
                    end
                end
            end
            tick();
            check("wrap_dense", {255'b0, out_valid == 2'b10}, 0);
            for (int l = 0; l < W; l++) begin
                if (out_valid[l]) begin
                    if (exp_q.size() == 0) check("wrap_extra", out_pc(l), 0);
                    else check("wrap_pc", out_pc(l), exp_q.pop_front());
                end
            end
        end
        clear_in();
        check("wrap_left", exp_q.size(), 0);
        check("wrap_ovf", overflow, 0);

        // async reset with entries queued and outputs active
        drain_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            clear_in();
            set_lane(0, 64'h6000 + 64'(8*c));
            if (c < 3) set_lane(1, 64'h6004 + 64'(8*c));
            tick();
        end
        clear_in();
        drain_en = 1'b1;
        tick();
        check("pre_rst_count", count, 5);
        check("pre_rst_valid", out_valid, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_rec", out_rec[0 +: REC_W], 0);
        check("arst_count", count, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_valid", out_valid, 0);
            check("post_rst_xcpt", out_int_xcpt, 0);
            check("post_rst_count", count, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
